// File: rtl/serial_deserializer.sv
// LSB-first serial-in/parallel-out receiver with a double-buffered valid/ready output.
// Optional even-parity frame bit enabled by defining SERIAL_DESER_PARITY_EN.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
`ifdef SERIAL_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             state_dbg
);

`ifdef SERIAL_DESER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  // Output handshake: data_out is transferred on any rising edge where
  // out_valid=1 and out_ready=1; out_ready has no effect while out_valid=0.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_q;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] word;
  logic             frame_done;
`ifdef SERIAL_DESER_PARITY_EN
  logic             perr_q, perr_d;
  logic             parity_bad;
`endif

  assign sr_shifted = {serial_in, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    frame_done = 1'b0;
    if (shift) begin
      sr_d = sr_shifted;
      if (cnt_q == LAST_CNT) begin
        cnt_d      = '0;
        frame_done = 1'b1;
        state_d    = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = RECV;
      end
    end
  end

  // With parity the final bit is the parity bit, so the word is sr before it lands.
`ifdef SERIAL_DESER_PARITY_EN
  assign word       = sr_q;
  assign parity_bad = serial_in ^ (^sr_q);
`else
  assign word = sr_shifted;
`endif

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef SERIAL_DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    if (frame_done) begin
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
        perr_d  = parity_bad;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= (cnt_d != '0);
`ifdef SERIAL_DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
  assign state_dbg = state_q;
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in, parallel-out receiver for the LSB-first bit stream produced by the team's parallel-load shift register.
- Collects WIDTH bits on qualified shift strobes, then transfers the completed word to an output holding register.
- Presents the held word with a valid/ready handshake.
- Double-buffered: a new frame can be collected while the previous word is still waiting for the consumer.

Parameters:
- WIDTH, 8, number of data bits per frame (must be at least 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit, sampled only when shift=1.
- shift  input  1  bit strobe; one bit is accepted per cycle in which shift=1.
- data_out  output  WIDTH  held received word; bit 0 is the first bit received.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts data_out on a clock edge where out_valid=1.
- busy  output  1  frame in progress: bit count is non-zero.
- overrun  output  1  sticky flag: a completed frame was dropped.
- parity_err  output  1  present only with PARITY_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high) clears everything to 0 immediately and holds it there while reset=1:
  - shift register sr and bit counter cnt
  - data_out, out_valid, busy, overrun and parity_err
- A reset asserted mid-frame discards the partial frame. The first shift after reset releases is bit 0 of a new frame.
- Shift path, on each rising edge with shift=1:
  - sr <= {serial_in, sr[WIDTH-1:1]} (shift right, new bit enters at the MSB).
  - cnt increments.
  - With shift=0, sr and cnt hold.
- Frame completion occurs on the edge that accepts bit number FRAME_LEN. FRAME_LEN = WIDTH, or WIDTH+1 with PARITY_EN. On that edge:
  - cnt returns to 0.
  - The word {serial_in, sr[WIDTH-1:1]} is the word offered for transfer. With PARITY_EN, the word is sr as it stands before the parity bit is accepted.
- Transfer rules, evaluated on the completion edge:
  - out_valid=0: data_out <= word; out_valid <= 1.
  - out_valid=1 and out_ready=1: the old word is consumed and the new word is loaded in the same edge. out_valid stays 1; no overrun.
  - out_valid=1 and out_ready=0: the new word is dropped. data_out is unchanged and overrun <= 1.
- Handshake, on non-completion edges: out_valid=1 and out_ready=1 clears out_valid. data_out holds its last value.
- out_ready is ignored while out_valid=0.
- Latency: out_valid and data_out update on the same edge that samples the final bit, so they are visible in the following cycle.
- Back-to-back frames: continuous shift=1 yields a new word every FRAME_LEN cycles with no dead cycle.
- busy = (cnt != 0). It is registered-derived and glitch-free.
- overrun is sticky; only reset clears it.
- Internal sequencing uses two states:
  - IDLE: cnt=0.
  - RECV: 0 < cnt < FRAME_LEN.
  - IDLE to RECV on the first shift; RECV to IDLE on completion or reset.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, where the expected parity bit equals the XOR of the data bits.
  - parity_err is loaded together with data_out: 1 on mismatch, 0 on match.
  - parity_err is held with the word. When a frame is dropped on overrun, its parity result is also discarded.
- Undefined:
  - Frames are exactly WIDTH bits.
  - The parity_err port and all parity logic are absent.

Test Plan:
1. WIDTH=8, shift=1 for 8 cycles with serial_in=1,0,1,0,0,1,0,1 and out_ready=0 -> after the 8th edge: data_out=8'hA5, out_valid=1, busy=0, overrun=0.
2. Same stream with shift=0 for 2 cycles between every bit -> identical result. busy=1 from the first bit until completion; cnt does not advance during gaps.
3. Stream 8'h3C then 8'hC3 back-to-back with out_ready=1 throughout -> out_valid rises after frame 1 and is cleared after one cycle; after frame 2: data_out=8'hC3, overrun=0.
4. Stream 8'h11 then 8'h22 with out_ready=0 -> data_out stays 8'h11, overrun=1. Then out_ready=1 for 1 cycle -> out_valid=0, overrun remains 1 until reset.
5. Reset pulsed mid-cycle after 3 bits -> all outputs 0 immediately. Then stream 8'h5A -> data_out=8'h5A, out_valid=1.
6. SERIAL_DESER_PARITY_EN defined: 8'hA5 followed by parity bit 0 -> parity_err=0; same with parity bit 1 -> parity_err=1; data_out=8'hA5 in both cases.
